// File: rtl/gs_residual.sv
// Gram-Schmidt residual stage: U = B - P and ||U||^2, sequenced over shared
// single-precision adders and multipliers by a start/done FSM.
module gs_residual #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N*W-1:0] B,
    input  logic [N*W-1:0] P,
    output logic [N*W-1:0] U,
    output logic [W-1:0]   norm_sq,
    output logic           done,
    output logic           busy
);

    typedef enum logic [2:0] {StIdle, StSub, StSq, StAdd1, StAdd2, StFin} state_e;

    // Single-precision add, round-to-nearest-even, denormals flushed to zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic              sx, sy;
        logic [7:0]        ea, eb, ex, d;
        logic [26:0]       mx, my, m;
        logic [27:0]       sum;
        logic signed [9:0] e;
        logic [24:0]       rnd;
        logic [4:0]        lz;
        logic              found;
        logic [31:0]       res;
        ea  = a[30:23];
        eb  = b[30:23];
        res = '0;
        if ((ea == 8'hFF && a[22:0] != '0) || (eb == 8'hFF && b[22:0] != '0)) begin
            res = 32'h7FC0_0000;
        end else if (ea == 8'hFF && eb == 8'hFF) begin
            res = (a[31] == b[31]) ? a : 32'h7FC0_0000;
        end else if (ea == 8'hFF) begin
            res = a;
        end else if (eb == 8'hFF) begin
            res = b;
        end else if (ea == '0 && eb == '0) begin
            res = {a[31] & b[31], 31'b0};
        end else if (ea == '0) begin
            res = b;
        end else if (eb == '0) begin
            res = a;
        end else begin
            if ({ea, a[22:0]} >= {eb, b[22:0]}) begin
                sx = a[31]; ex = ea; mx = {1'b1, a[22:0], 3'b0};
                sy = b[31]; d = ea - eb; my = {1'b1, b[22:0], 3'b0};
            end else begin
                sx = b[31]; ex = eb; mx = {1'b1, b[22:0], 3'b0};
                sy = a[31]; d = eb - ea; my = {1'b1, a[22:0], 3'b0};
            end
            // Align the smaller operand, folding shifted-out bits into sticky.
            if (d >= 8'd27) begin
                my = 27'd1;
            end else begin
                my = (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
            end
            e = signed'({2'b00, ex});
            if (sx == sy) begin
                sum = {1'b0, mx} + {1'b0, my};
                if (sum[27]) begin
                    m = {sum[27:2], sum[1] | sum[0]};
                    e = e + 10'sd1;
                end else begin
                    m = sum[26:0];
                end
            end else begin
                m = mx - my;
            end
            if (m == '0) begin
                res = '0;
            end else begin
                lz    = '0;
                found = 1'b0;
                for (int i = 26; i >= 0; i--) begin
                    if (!found && m[i]) begin
                        lz    = 5'(26 - i);
                        found = 1'b1;
                    end
                end
                m = m << lz;
                e = e - signed'({5'd0, lz});
                if (e <= 10'sd0) begin
                    res = {sx, 31'b0};
                end else begin
                    rnd = {1'b0, m[26:3]} + {24'd0, m[2] & (m[1] | m[0] | m[3])};
                    if (rnd[24]) begin
                        rnd = rnd >> 1;
                        e   = e + 10'sd1;
                    end
                    res = (e >= 10'sd255) ? {sx, 8'hFF, 23'b0} : {sx, e[7:0], rnd[22:0]};
                end
            end
        end
        return res;
    endfunction

    // Single-precision multiply, round-to-nearest-even, denormals flushed to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
        logic [47:0]       prod;
        logic [23:0]       keep;
        logic [24:0]       rnd;
        logic signed [9:0] e;
        logic [31:0]       res;
        s      = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        a_zero = (a[30:23] == '0);
        b_zero = (b[30:23] == '0);
        res    = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            res = {s, 8'hFF, 23'b0};
        end else if (a_zero || b_zero) begin
            res = {s, 31'b0};
        end else begin
            prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
            e    = signed'({2'b00, a[30:23]}) + signed'({2'b00, b[30:23]}) - 10'sd127;
            if (prod[47]) begin
                keep = prod[47:24];
                g    = prod[23];
                st   = |prod[22:0];
                e    = e + 10'sd1;
            end else begin
                keep = prod[46:23];
                g    = prod[22];
                st   = |prod[21:0];
            end
            rnd = {1'b0, keep} + {24'd0, g & (st | keep[0])};
            if (rnd[24]) begin
                rnd = rnd >> 1;
                e   = e + 10'sd1;
            end
            if (e <= 10'sd0) begin
                res = {s, 31'b0};
            end else if (e >= 10'sd255) begin
                res = {s, 8'hFF, 23'b0};
            end else begin
                res = {s, e[7:0], rnd[22:0]};
            end
        end
        return res;
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   b_q [N], b_d [N], p_q [N], p_d [N];
    logic [W-1:0]   add_a_q [N], add_a_d [N], add_b_q [N], add_b_d [N];
    logic [W-1:0]   mul_q [N], mul_d [N];
    logic [W-1:0]   u_q [N], u_d [N];
    logic [W-1:0]   add_res [N], mul_res [N];
    logic [W-1:0]   norm_q, norm_d;
    logic           done_q, done_d;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            add_res[i] = fp_add(add_a_q[i], add_b_q[i]);
            mul_res[i] = fp_mul(mul_q[i], mul_q[i]);
        end
    end

    // Element 0 sits in the top word of each packed vector.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        p_d     = p_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        mul_d   = mul_q;
        u_d     = u_q;
        norm_d  = norm_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        b_d[i] = B[(N-1-i)*W +: W];
                        p_d[i] = P[(N-1-i)*W +: W];
                    end
                    state_d = StSub;
                end
            end
            StSub: begin
                for (int i = 0; i < N; i++) begin
                    add_a_d[i] = b_q[i];
                    add_b_d[i] = {~p_q[i][W-1], p_q[i][W-2:0]};
                end
                state_d = StSq;
            end
            StSq: begin
                u_d     = add_res;
                mul_d   = add_res;
                state_d = StAdd1;
            end
            StAdd1: begin
                add_a_d[0] = mul_res[0];
                add_b_d[0] = mul_res[1];
                add_a_d[1] = mul_res[2];
                add_b_d[1] = mul_res[3];
                state_d    = StAdd2;
            end
            StAdd2: begin
                add_a_d[0] = add_res[0];
                add_b_d[0] = add_res[1];
                state_d    = StFin;
            end
            StFin: begin
                norm_d  = add_res[0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            norm_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                b_q[i]     <= '0;
                p_q[i]     <= '0;
                add_a_q[i] <= '0;
                add_b_q[i] <= '0;
                mul_q[i]   <= '0;
                u_q[i]     <= '0;
            end
        end else begin
            state_q <= state_d;
            norm_q  <= norm_d;
            done_q  <= done_d;
            b_q     <= b_d;
            p_q     <= p_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            mul_q   <= mul_d;
            u_q     <= u_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            U[(N-1-i)*W +: W] = u_q[i];
        end
    end

    assign norm_sq = norm_q;
    assign done    = done_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: doc/gs_residual.md
Name: gs_residual

Overview:
- Gram-Schmidt stage placed directly downstream of the projection unit.
- Takes the original column B and the projection P = <B,A>A, both 4 x 32-bit IEEE-754 single-precision vectors.
- Computes the orthogonal residual U = B - P and its squared norm ||U||^2 = <U,U>.
- The normalisation stage that follows consumes both results to form the next orthonormal column of Q for the 2x2 MIMO ZF detector.
- Built from the team's combinational single-precision `mul` and `adder` units, sequenced by a start/done FSM.

Parameters:
- W, 32, element width in bits. Fixed to single precision; no other value is supported.
- N, 4, number of elements per vector. Fixed; the packing rules below assume 4.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request. Accepted only in IDLE.
- B  input  128  original vector. Element0 [127:96], element1 [95:64], element2 [63:32], element3 [31:0].
- P  input  128  projection vector, same packing as B. Driven by the projection unit's proj output.
- U  output  128  residual B - P, same packing as B.
- norm_sq  output  32  U0^2 + U1^2 + U2^2 + U3^2
- done  output  1  one-cycle pulse; U and norm_sq are valid from this cycle on.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While reset is high at a rising edge, on that edge:
  - state goes to IDLE;
  - U, norm_sq, done, busy and all internal operand/pipeline registers go to 0.
- Reset mid-operation: the computation is abandoned, nothing completes, and no done pulse is produced.
- States: IDLE -> SUB -> SQ -> ADD1 -> ADD2 -> FIN -> IDLE. No other transitions.
- IDLE:
  - On start=1, capture B and P into internal operand registers, then go to SUB.
  - B and P need only be valid on the accepting edge.
- SUB: load the 4 adders with (B_i, P_i with bit 31 inverted), i.e. B_i + (-P_i). Go to SQ.
- SQ:
  - Register the 4 adder results into U (updated here, ahead of done).
  - Load mul_i with (U_i, U_i).
  - Go to ADD1.
- ADD1: load adder1 with (mul0, mul1) and adder2 with (mul2, mul3). Go to ADD2.
- ADD2: load adder1 with (adder1 result, adder2 result). Go to FIN.
- FIN: register adder1 result into norm_sq and drive done to 1 on the same edge. Go to IDLE.
- Latency:
  - Take edge 0 as the edge that accepts start. done is high in the cycle following edge 5.
  - norm_sq is valid in that same cycle.
  - U is valid from edge 2, but consumers use done.
- done: registered, high for exactly one cycle per accepted start.
- busy: high from the cycle after edge 0 through FIN.
- Back-to-back: start may be asserted in the done cycle, since the state is IDLE then. Minimum start-to-start spacing is 6 cycles.
- start while busy: ignored entirely, not queued. No effect on the operation in progress.
- Hold: U and norm_sq keep their values until overwritten by the next operation or cleared by reset.
- Arithmetic:
  - Results are bit-exact with the team's `mul`/`adder` units.
  - Negation is a sign-bit flip only.
  - Inf/NaN/denormal handling is inherited from those units; no flags are raised.
  - Summation order is fixed as (U0^2 + U1^2) + (U2^2 + U3^2).
- start=1 during reset: ignored.

Test Plan:
- Basic case:
  - Stimulus: B = {0x40000000, 0x40400000, 0x40800000, 0x40A00000} (2,3,4,5); P = all 0x3F800000 (1.0); pulse start.
  - Required: U = {0x3F800000, 0x40000000, 0x40400000, 0x40800000}; norm_sq = 0x41F00000 (30.0); done exactly 5 edges after accept, one cycle wide.
- B equal to P:
  - Stimulus: B = P = {2,3,4,5}.
  - Required: U = all 0x00000000; norm_sq = 0x00000000.
- Negative P:
  - Stimulus: B = 0; P = all 0xBF800000 (-1.0).
  - Required: U = all 0x3F800000; norm_sq = 0x40800000 (4.0).
- Start while busy:
  - Stimulus: start the basic case, then re-pulse start with different B/P in SQ and in ADD2.
  - Required: results still 0x41F00000 etc.; exactly one done pulse; busy stays high throughout.
- Reset mid-operation:
  - Stimulus: assert reset in ADD1 for one cycle.
  - Required: next cycle U = 0, norm_sq = 0, busy = 0; no done. A following start computes correctly.
- Back-to-back:
  - Stimulus: assert the second start (the negative-P case) in the done cycle of the first.
  - Required: second done occurs 6 cycles after the first; outputs hold the first results until they are overwritten by the second.
